rst_req_seq: RTL and testbench

- Reset-request sequencer: the initiating end of the FIFO reset path.
- Accepts a soft-reset request over a req/ack handshake (and, optionally, a watchdog timeout). Produces a stretched, glitch-free active-low reset `rst_out_n`.
- `rst_out_n` drives the `reset_n` input of downstream async-assert/sync-deassert reset synchronizers.
- After releasing `rst_out_n`, waits a settle window, then reports completion with `done`.

---
 rtl/rst_req_seq_if.sv | 21 ++
 rtl/rst_req_seq.sv | 143 ++++++++++++++
 tb/tb_rst_req_seq.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rst_req_seq_if.sv
// Handshake and status bundle for the reset-request sequencer.
// master = requester / reset consumer side, slave = the sequencer itself.
interface rst_req_seq_if;
    logic req;
    logic ack;
    logic wdog_kick;
    logic rst_out_n;
    logic busy;
    logic done;
    logic wdog_fired;

    modport master (
        output req, wdog_kick,
        input  ack, rst_out_n, busy, done, wdog_fired
    );

    modport slave (
        input  req, wdog_kick,
        output ack, rst_out_n, busy, done, wdog_fired
    );
endinterface

// File: rtl/rst_req_seq.sv
// Reset-request sequencer: accepts a soft-reset request (req/ack), drives a
// stretched registered active-low reset, waits a settle window, pulses done.
// Optional watchdog source enabled by defining RST_REQ_SEQ_WDOG_EN.
// The single counter is shared: hold/settle count in ASSERT/SETTLE, watchdog
// idle count in IDLE (held at 0 there when the watchdog is compiled out).
module rst_req_seq #(
    parameter int CNT_W         = 16,
    parameter int HOLD_CYCLES   = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int WDOG_CYCLES   = 1024
) (
    input  logic         clock,
    input  logic         reset_n,
    rst_req_seq_if.slave bus
);

    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_cnt_w
        $error("rst_req_seq: CNT_W out of range");
    end
    if (HOLD_CYCLES < 1 || HOLD_CYCLES > CNT_MAX) begin : g_bad_hold
        $error("rst_req_seq: HOLD_CYCLES out of range");
    end
    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > CNT_MAX) begin : g_bad_settle
        $error("rst_req_seq: SETTLE_CYCLES out of range");
    end
    if (WDOG_CYCLES < 2 || WDOG_CYCLES > CNT_MAX) begin : g_bad_wdog
        $error("rst_req_seq: WDOG_CYCLES out of range");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
`ifdef RST_REQ_SEQ_WDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LAST   = CNT_W'(WDOG_CYCLES - 1);
`endif

    typedef enum logic [1:0] {IDLE, ASSERT, SETTLE} state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             start_req, start_wdog;
    logic             rst_out_n, busy, ack, done;
    logic             rst_out_n_d, busy_d, ack_d, done_d;

    // State, counter and registered outputs; reset lands in ASSERT so a
    // power-on reset gets the same stretch as a soft request.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ASSERT;
            cnt       <= '0;
            rst_out_n <= 1'b0;
            busy      <= 1'b1;
            ack       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            rst_out_n <= rst_out_n_d;
            busy      <= busy_d;
            ack       <= ack_d;
            done      <= done_d;
        end
    end

    // Next state and counter; req beats watchdog expiry, kick beats expiry.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        start_req  = 1'b0;
        start_wdog = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (bus.req) begin
                    start_req = 1'b1;
                    state_d   = ASSERT;
                end
`ifdef RST_REQ_SEQ_WDOG_EN
                else if (bus.wdog_kick) begin
                    cnt_d = '0;
                end else if (cnt == WDOG_LAST) begin
                    start_wdog = 1'b1;
                    state_d    = ASSERT;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
`endif
            end
            ASSERT: begin
                if (cnt == HOLD_LAST) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = ASSERT;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values for the next cycle, derived from the transition taken.
    always_comb begin
        rst_out_n_d = (state_d != ASSERT);
        busy_d      = (state_d != IDLE);
        ack_d       = start_req;
        done_d      = (state == SETTLE) && (state_d == IDLE);
    end

`ifdef RST_REQ_SEQ_WDOG_EN
    logic wdog_fired;

    // Sticky source flag: set by a watchdog start, cleared by an accepted req.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)        wdog_fired <= 1'b0;
        else if (start_req)  wdog_fired <= 1'b0;
        else if (start_wdog) wdog_fired <= 1'b1;
    end

    assign bus.wdog_fired = wdog_fired;
`else
    logic unused_kick;
    assign unused_kick    = bus.wdog_kick ^ start_wdog;
    assign bus.wdog_fired = 1'b0;
`endif

    assign bus.rst_out_n = rst_out_n;
    assign bus.busy      = busy;
    assign bus.ack       = ack;
    assign bus.done      = done;

endmodule

// File: tb/tb_rst_req_seq.sv
// Self-checking bench for rst_req_seq. The reference model tracks only the
// edge at which the current sequence started and the edge of the last
// watchdog service; expected outputs follow from elapsed-edge arithmetic.
module tb_rst_req_seq;
    localparam int HOLD   = 16;
    localparam int SETTLE = 4;
    localparam int WDOG   = 8;
    localparam int SEQ    = HOLD + SETTLE;
`ifdef RST_REQ_SEQ_WDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b1;

    rst_req_seq_if bus();

    rst_req_seq #(
        .CNT_W(16), .HOLD_CYCLES(HOLD), .SETTLE_CYCLES(SETTLE), .WDOG_CYCLES(WDOG)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    int     n_cmp = 0;
    int     n_err = 0;
    longint edge_no   = 0;
    longint seq_start = -1000;
    longint last_ref  = -1000;
    bit     m_ack = 1'b0;
    bit     m_wf  = 1'b0;

    // One clock: update the model from the inputs seen at the edge, then
    // leave time #1 after the edge for sampling and driving.
    task automatic clk_step();
        bit idle;
        @(posedge clock);
        edge_no++;
        m_ack = 1'b0;
        idle  = (edge_no - 1 - seq_start) >= SEQ;
        if (!reset_n) begin
            seq_start = edge_no;
            last_ref  = edge_no + SEQ;
            m_wf      = 1'b0;
        end else if (idle) begin
            if (bus.req) begin
                seq_start = edge_no;
                last_ref  = edge_no + SEQ;
                m_ack     = 1'b1;
                m_wf      = 1'b0;
            end else if (bus.wdog_kick) begin
                last_ref = edge_no;
            end else if (WD_EN && (edge_no - last_ref) >= WDOG) begin
                seq_start = edge_no;
                last_ref  = edge_no + SEQ;
                m_wf      = 1'b1;
            end
        end
        #1;
    endtask

    // {rst_out_n, busy, ack, done, wdog_fired}
    function automatic logic [4:0] exp_vec();
        longint age;
        age = edge_no - seq_start;
        return {age >= HOLD, age < SEQ, m_ack, age == SEQ, m_wf};
    endfunction

    function automatic logic [4:0] obs();
        return {bus.rst_out_n, bus.busy, bus.ack, bus.done, bus.wdog_fired};
    endfunction

    task automatic test_reset();
        bus.req = 1'b0;
        bus.wdog_kick = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 5'b01000) begin
            n_err++; $display("FAIL reset_async: got %b want %b", obs(), 5'b01000);
        end
        repeat (3) clk_step();
        n_cmp++;
        if (obs() !== 5'b01000) begin
            n_err++; $display("FAIL reset_hold: got %b want %b", obs(), 5'b01000);
        end
        reset_n = 1'b1;
        for (int i = 1; i <= SEQ + 2; i++) begin
            clk_step();
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_err++; $display("FAIL por_model c%0d: got %b want %b", i, obs(), exp_vec());
            end
            n_cmp++;
            if (bus.rst_out_n !== (i >= HOLD) || bus.done !== (i == SEQ)) begin
                n_err++; $display("FAIL por_timing c%0d: got rst_out_n=%b done=%b want %b %b",
                                  i, bus.rst_out_n, bus.done, i >= HOLD, i == SEQ);
            end
        end
    endtask

    task automatic test_soft_req();
        repeat (3) clk_step();
        bus.req = 1'b1;
        clk_step();
        n_cmp++;
        if (bus.ack !== 1'b1 || bus.rst_out_n !== 1'b0 || bus.busy !== 1'b1) begin
            n_err++; $display("FAIL soft_accept: got ack=%b rst_out_n=%b busy=%b want 1 0 1",
                              bus.ack, bus.rst_out_n, bus.busy);
        end
        clk_step();
        bus.req = 1'b0;
        n_cmp++;
        if (bus.ack !== 1'b0) begin
            n_err++; $display("FAIL soft_ack_pulse: got %b want 0", bus.ack);
        end
        for (int i = 2; i <= SEQ + 3; i++) begin
            clk_step();
            n_cmp++;
            if (obs() !== exp_vec() || bus.rst_out_n !== (i >= HOLD) || bus.done !== (i == SEQ)
                || bus.ack !== 1'b0) begin
                n_err++; $display("FAIL soft_seq c%0d: got %b want %b", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_req_while_busy();
        longint s;
        bit     got;
        longint ack_at;
        int     extra;
        got = 1'b0; ack_at = -1; extra = 0;
        bus.req = 1'b1;
        clk_step();
        s = edge_no;
        bus.req = 1'b0;
        repeat (4) clk_step();
        bus.req = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            clk_step();
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_err++; $display("FAIL busy_model e%0d: got %b want %b", edge_no - s, obs(), exp_vec());
            end
            if (bus.ack) begin
                got = 1'b1;
                ack_at = edge_no - s;
            end
        end
        bus.req = 1'b0;
        n_cmp++;
        if (ack_at != SEQ + 1) begin
            n_err++; $display("FAIL busy_ack_edge: got %0d want %0d", ack_at, SEQ + 1);
        end
        for (int i = 0; i < SEQ + 4; i++) begin
            clk_step();
            if (bus.ack) extra++;
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_err++; $display("FAIL busy_reseq c%0d: got %b want %b", i, obs(), exp_vec());
            end
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++; $display("FAIL busy_extra_ack: got %0d want 0", extra);
        end
    endtask

    task automatic test_reset_mid_settle();
        int dones;
        dones = 0;
        bus.req = 1'b1;
        clk_step();
        bus.req = 1'b0;
        repeat (HOLD + 2) clk_step();
        n_cmp++;
        if (obs() !== 5'b11000) begin
            n_err++; $display("FAIL mid_settle_pre: got %b want %b", obs(), 5'b11000);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 5'b01000) begin
            n_err++; $display("FAIL mid_settle_async: got %b want %b", obs(), 5'b01000);
        end
        clk_step();
        reset_n = 1'b1;
        for (int i = 1; i <= SEQ + 2; i++) begin
            clk_step();
            if (bus.done) dones++;
            n_cmp++;
            if (obs() !== exp_vec() || bus.done !== (i == SEQ)) begin
                n_err++; $display("FAIL mid_settle_seq c%0d: got %b want %b", i, obs(), exp_vec());
            end
        end
        n_cmp++;
        if (dones != 1) begin
            n_err++; $display("FAIL mid_settle_dones: got %0d want 1", dones);
        end
    endtask

`ifdef RST_REQ_SEQ_WDOG_EN
    task automatic test_watchdog();
        bus.req = 1'b1;
        clk_step();
        bus.req = 1'b0;
        repeat (SEQ) clk_step();
        for (int i = 1; i < WDOG; i++) begin
            clk_step();
            n_cmp++;
            if (bus.rst_out_n !== 1'b1 || obs() !== exp_vec()) begin
                n_err++; $display("FAIL wdog_quiet c%0d: got %b want %b", i, obs(), exp_vec());
            end
        end
        clk_step();
        n_cmp++;
        if (obs() !== 5'b01001) begin
            n_err++; $display("FAIL wdog_fire: got %b want %b", obs(), 5'b01001);
        end
        repeat (SEQ + WDOG - 1) clk_step();
        bus.wdog_kick = 1'b1;
        clk_step();
        bus.wdog_kick = 1'b0;
        n_cmp++;
        if (bus.rst_out_n !== 1'b1 || bus.busy !== 1'b0 || obs() !== exp_vec()) begin
            n_err++; $display("FAIL wdog_kick_wins: got %b want %b", obs(), exp_vec());
        end
        for (int i = 0; i < 100; i++) begin
            bus.wdog_kick = (i % 5 == 0);
            clk_step();
            n_cmp++;
            if (bus.rst_out_n !== 1'b1 || obs() !== exp_vec()) begin
                n_err++; $display("FAIL wdog_kicked c%0d: got %b want %b", i, obs(), exp_vec());
            end
        end
        bus.wdog_kick = 1'b1;
        clk_step();
        bus.wdog_kick = 1'b0;
        repeat (WDOG - 1) clk_step();
        bus.req = 1'b1;
        clk_step();
        bus.req = 1'b0;
        n_cmp++;
        if (obs() !== 5'b01100) begin
            n_err++; $display("FAIL wdog_req_wins: got %b want %b", obs(), 5'b01100);
        end
        repeat (SEQ + 2) clk_step();
    endtask
`else
    task automatic test_no_wdog();
        int bad;
        bad = 0;
        bus.req = 1'b0;
        bus.wdog_kick = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            clk_step();
            if (bus.rst_out_n !== 1'b1 || bus.wdog_fired !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL no_wdog_idle: got %0d bad cycles want 0", bad);
        end
        n_cmp++;
        if (obs() !== exp_vec()) begin
            n_err++; $display("FAIL no_wdog_model: got %b want %b", obs(), exp_vec());
        end
    endtask
`endif

    task automatic test_random();
        bit pending;
        pending = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!pending && $urandom_range(0, 9) == 0) begin
                pending = 1'b1;
                bus.req = 1'b1;
            end
            bus.wdog_kick = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 199) == 0) reset_n = 1'b0;
            clk_step();
            reset_n = 1'b1;
            n_cmp++;
            if (obs() !== exp_vec()) begin
                n_err++; $display("FAIL random c%0d: got %b want %b", i, obs(), exp_vec());
            end
            if (bus.ack) begin
                pending = 1'b0;
                bus.req = 1'b0;
            end
        end
        bus.req = 1'b0;
        bus.wdog_kick = 1'b0;
    endtask

    initial begin
        bus.req = 1'b0;
        bus.wdog_kick = 1'b0;
        test_reset();
        test_soft_req();
        test_req_while_busy();
        test_reset_mid_settle();
`ifdef RST_REQ_SEQ_WDOG_EN
        test_watchdog();
`else
        test_no_wdog();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish want finish before time limit");
        $fatal(1, "time limit reached");
    end

endmodule
